// File: rtl/rv32i_types_pkg.sv
// Shared types and sizing helpers for the scoreboarded integer register file.
// No logic; latency and backpressure are not applicable.
package rv32i_types_pkg;

    localparam int ZERO_REG     = 0;
    localparam int DEF_MAX_PEND = 3;

    function automatic int addr_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

    function automatic int cnt_w(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

    // Pending-claim count at the default MAX_PEND depth.
    typedef logic [cnt_w(DEF_MAX_PEND)-1:0] sb_cnt_t;

endpackage

// File: rtl/rv32i_sb_reg_file_if.sv
// Issue/writeback bus of the scoreboarded register file.
// Reads and claim_ready are combinational; there is no backpressure beyond claim_ready.
interface rv32i_sb_reg_file_if #(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2
);
    import rv32i_types_pkg::*;

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [NUM_RD_PORTS*ADDR_W-1:0]     rs_addr;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_data;
    logic [NUM_RD_PORTS-1:0]            rs_busy;
    logic                               claim_en;
    logic [ADDR_W-1:0]                  claim_addr;
    logic                               claim_ready;
    logic [NUM_WR_PORTS-1:0]            wen;
    logic [NUM_WR_PORTS*ADDR_W-1:0]     waddr;
    logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wdata;
    logic [NUM_WR_PORTS-1:0]            wrelease;
    logic                               flush;
    logic                               any_busy;
    logic                               sb_err;

    modport master (
        output rs_addr, claim_en, claim_addr, wen, waddr, wdata, wrelease, flush,
        input  rs_data, rs_busy, claim_ready, any_busy, sb_err
    );

    modport slave (
        input  rs_addr, claim_en, claim_addr, wen, waddr, wdata, wrelease, flush,
        output rs_data, rs_busy, claim_ready, any_busy, sb_err
    );

endinterface

// File: rtl/rv32i_sb_counter.sv
// Saturating up/down pending-claim counter for one register.
// Count updates at the edge; underflow is combinational; clr wins and suppresses underflow.
module rv32i_sb_counter #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 2,
    parameter int DEC_W    = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec_count,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_max,
    output logic             underflow
);
    localparam int SUM_W = CNT_W + DEC_W + 1;

    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] nxt;

    always_comb begin
        up        = SUM_W'(count) + SUM_W'(inc);
        underflow = !clr && (up < SUM_W'(dec_count));
        nxt       = underflow ? '0 : up - SUM_W'(dec_count);
        if (nxt > SUM_W'(MAX_PEND)) begin
            nxt = SUM_W'(MAX_PEND);
        end
    end

    assign at_max = (count == CNT_W'(MAX_PEND));

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count <= '0;
        end else begin
            count <= nxt[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/rv32i_sb_reg_file.sv
// Multi-port register file with per-register counting scoreboard and sticky protocol error.
// Writes/counts land at the edge; reads and claim_ready are combinational; full counters refuse claims.
module rv32i_sb_reg_file
    import rv32i_types_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2,
    parameter int MAX_PEND     = 3,
    parameter int BYPASS       = 1
) (
    input  logic                CLK,
    input  logic                RST,
    rv32i_sb_reg_file_if.slave  bus
);
    localparam int ADDR_W = addr_w(NUM_REGS);
    localparam int CNT_W  = cnt_w(MAX_PEND);
    localparam int DEC_W  = $clog2(NUM_WR_PORTS + 1);

    logic [DATA_WIDTH-1:0]             regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0]             wr_val [NUM_REGS];
    logic [NUM_REGS-1:0]               wr_hit;
    logic [NUM_REGS-1:0][DEC_W-1:0]    rel_cnt;
    logic [NUM_REGS-1:0][CNT_W-1:0]    counts;
    logic [NUM_REGS-1:0]               at_max;
    logic [NUM_REGS-1:0]               underflow;
    logic [ADDR_W-1:0]                 wa;
    logic [ADDR_W-1:0]                 rd_addr;
    logic                              claim_rdy_c;
    logic                              claim_valid;
    logic                              claim_ok;
    logic                              claim_err;
    logic                              sb_err_q;

    // Per-register view of this cycle's writes: later ports overwrite earlier ones.
    always_comb begin
        wa      = '0;
        wr_hit  = '0;
        rel_cnt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_val[r] = '0;
        end
        for (int i = 0; i < NUM_WR_PORTS; i++) begin
            wa = bus.waddr[i*ADDR_W +: ADDR_W];
            if (bus.wen[i] && wa != ADDR_W'(ZERO_REG)) begin
                wr_hit[wa] = 1'b1;
                wr_val[wa] = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
                if (bus.wrelease[i]) begin
                    rel_cnt[wa] = rel_cnt[wa] + DEC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // A full counter still takes a claim when a same-cycle release frees a slot.
    assign claim_rdy_c = !(at_max[bus.claim_addr] && rel_cnt[bus.claim_addr] == '0);
    assign claim_valid = bus.claim_en && !bus.flush && bus.claim_addr != ADDR_W'(ZERO_REG);
    assign claim_ok    = claim_valid && claim_rdy_c;
    assign claim_err   = claim_valid && !claim_rdy_c;

    assign counts[0]    = '0;
    assign at_max[0]    = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        rv32i_sb_counter #(
            .MAX_PEND (MAX_PEND),
            .CNT_W    (CNT_W),
            .DEC_W    (DEC_W)
        ) u_cnt (
            .CLK       (CLK),
            .RST       (RST),
            .inc       (claim_ok && bus.claim_addr == ADDR_W'(r)),
            .dec_count (rel_cnt[r]),
            .clr       (bus.flush),
            .count     (counts[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sb_err_q <= 1'b0;
        end else if (claim_err || |underflow) begin
            sb_err_q <= 1'b1;
        end
    end

    always_comb begin
        rd_addr     = '0;
        bus.rs_data = '0;
        bus.rs_busy = '0;
        for (int j = 0; j < NUM_RD_PORTS; j++) begin
            rd_addr = bus.rs_addr[j*ADDR_W +: ADDR_W];
            if (rd_addr != ADDR_W'(ZERO_REG)) begin
                if (BYPASS != 0 && wr_hit[rd_addr]) begin
                    bus.rs_data[j*DATA_WIDTH +: DATA_WIDTH] = wr_val[rd_addr];
                end else begin
                    bus.rs_data[j*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr];
                end
                if (BYPASS != 0) begin
                    bus.rs_busy[j] = {{DEC_W{1'b0}}, counts[rd_addr]} >
                                     {{CNT_W{1'b0}}, rel_cnt[rd_addr]};
                end else begin
                    bus.rs_busy[j] = (counts[rd_addr] != '0);
                end
            end
        end
    end

    assign bus.claim_ready = claim_rdy_c;
    assign bus.any_busy    = |counts;
    assign bus.sb_err      = sb_err_q;

endmodule

// File: tb/tb_rv32i_sb_reg_file.sv
// Directed bench for rv32i_sb_reg_file (BYPASS=1): reset sweep plus a cycle-by-cycle vector table.
module tb_rv32i_sb_reg_file;

    logic CLK;
    logic RST;
    int   n_chk;
    int   n_fail;

    rv32i_sb_reg_file_if #(
        .NUM_REGS(32), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)
    ) sb_if ();

    rv32i_sb_reg_file #(
        .NUM_REGS(32), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2),
        .MAX_PEND(3), .BYPASS(1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (sb_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One row = inputs held for one cycle plus the combinational outputs expected in that cycle.
    typedef struct {
        int rst;
        int wen, wrel, wa0, wa1, wd0, wd1;
        int cen, ca, fl;
        int ra0, ra1;
        int e_d0, e_d1, e_busy, e_cr, e_any, e_err;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        RST               = (v.rst != 0);
        sb_if.wen         = 2'(v.wen);
        sb_if.wrelease    = 2'(v.wrel);
        sb_if.waddr       = {5'(v.wa1), 5'(v.wa0)};
        sb_if.wdata       = {32'(v.wd1), 32'(v.wd0)};
        sb_if.claim_en    = (v.cen != 0);
        sb_if.claim_addr  = 5'(v.ca);
        sb_if.flush       = (v.fl != 0);
        sb_if.rs_addr     = {5'(v.ra1), 5'(v.ra0)};
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        drive(vec_t'{1, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0});
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        for (int r = 0; r < 32; r++) begin
            sb_if.rs_addr    = {5'(31 - r), 5'(r)};
            sb_if.claim_addr = 5'(r);
            #3;
            chk("reset_rs_data0", r, sb_if.rs_data[31:0], 32'h0);
            chk("reset_rs_data1", r, sb_if.rs_data[63:32], 32'h0);
            chk("reset_rs_busy", r, 32'(sb_if.rs_busy), 32'h0);
            chk("reset_claim_ready", r, 32'(sb_if.claim_ready), 32'h1);
            chk("reset_any_busy", r, 32'(sb_if.any_busy), 32'h0);
            chk("reset_sb_err", r, 32'(sb_if.sb_err), 32'h0);
            @(posedge CLK);
            #1;
        end

        //                 rst wen wrl wa0 wa1 wd0           wd1           cen ca fl ra0 ra1 e_d0          e_d1          busy cr any err
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 5, 0,            0,            0, 1, 0, 0});
        // write-port priority, bypassed in the same cycle
        tv.push_back(vec_t'{0, 3, 0, 5, 5, 32'h1234,     32'hAAAA0000, 0, 0, 0, 5, 0, 32'hAAAA0000, 0,            0, 1, 0, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 5, 6, 32'hAAAA0000, 0,            0, 1, 0, 0});
        // fill reg7 to MAX_PEND, then an over-claim
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 7, 0, 7, 5, 0,            32'hAAAA0000, 0, 1, 0, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 7, 0, 7, 5, 0,            32'hAAAA0000, 1, 1, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 7, 0, 7, 5, 0,            32'hAAAA0000, 1, 1, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 7, 0, 7, 5, 0,            32'hAAAA0000, 1, 0, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 7, 0, 7, 5, 0,            32'hAAAA0000, 1, 0, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 7, 0, 7, 5, 0,            32'hAAAA0000, 1, 0, 1, 1});
        // drain reg7: one release, then two summed releases
        tv.push_back(vec_t'{0, 1, 1, 7, 0, 32'h70,       0,            0, 7, 0, 7, 5, 32'h70,       32'hAAAA0000, 1, 1, 1, 1});
        tv.push_back(vec_t'{0, 3, 3, 7, 7, 32'h71,       32'h72,       0, 7, 0, 7, 5, 32'h72,       32'hAAAA0000, 0, 1, 1, 1});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 7, 0, 7, 5, 32'h72,       32'hAAAA0000, 0, 1, 0, 1});
        tv.push_back(vec_t'{1, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0});
        // reg9 at MAX_PEND with simultaneous claim and release
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 9, 0, 9, 0, 0,            0,            0, 1, 0, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 9, 0, 9, 0, 0,            0,            1, 1, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 9, 0, 9, 0, 0,            0,            1, 1, 1, 0});
        tv.push_back(vec_t'{0, 2, 2, 0, 9, 0,            32'h99,       1, 9, 0, 9, 0, 32'h99,       0,            1, 1, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 9, 0, 9, 0, 32'h99,       0,            1, 0, 1, 0});
        // underflow on reg3, sticky until reset
        tv.push_back(vec_t'{0, 1, 1, 3, 0, 32'h33,       0,            0, 3, 0, 3, 9, 32'h33,       32'h99,       2, 1, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 9, 0, 3, 9, 32'h33,       32'h99,       2, 0, 1, 1});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 9, 0, 3, 9, 32'h33,       32'h99,       2, 0, 1, 1});
        tv.push_back(vec_t'{1, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 9, 0, 3, 9, 0,            0,            0, 1, 0, 0});
        // flush: reg4=2, reg6=1, same-cycle write+release to reg4 and claim of reg6
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 4, 0, 4, 6, 0,            0,            0, 1, 0, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 4, 0, 4, 6, 0,            0,            1, 1, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            1, 6, 0, 4, 6, 0,            0,            1, 1, 1, 0});
        tv.push_back(vec_t'{0, 1, 1, 4, 0, 32'h55,       0,            1, 6, 1, 4, 6, 32'h55,       0,            3, 1, 1, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 6, 0, 4, 6, 32'h55,       0,            0, 1, 0, 0});
        // flush keeps an already-set error
        tv.push_back(vec_t'{0, 1, 1, 6, 0, 32'h66,       0,            0, 6, 0, 4, 6, 32'h55,       32'h66,       0, 1, 0, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 6, 1, 4, 6, 32'h55,       32'h66,       0, 1, 0, 1});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 6, 0, 4, 6, 32'h55,       32'h66,       0, 1, 0, 1});
        tv.push_back(vec_t'{1, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0});
        // register 0 ignores writes, releases and claims
        tv.push_back(vec_t'{0, 3, 3, 0, 0, 32'hFFFF,     32'hFFFF,     1, 0, 0, 0, 0, 0,            0,            0, 1, 0, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 4, 0,            0,            0, 1, 0, 0});
        // reset discards a same-cycle write and claim
        tv.push_back(vec_t'{1, 1, 0, 10, 0, 32'hDEAD,    0,            1, 10, 0, 0, 0, 0,           0,            0, 0, 0, 0});
        tv.push_back(vec_t'{0, 0, 0, 0, 0, 0,            0,            0, 10, 0, 10, 10, 0,         0,            0, 1, 0, 0});

        foreach (tv[k]) begin
            drive(tv[k]);
            #3;
            if (tv[k].rst == 0) begin
                chk("rs_data0", k, sb_if.rs_data[31:0], 32'(tv[k].e_d0));
                chk("rs_data1", k, sb_if.rs_data[63:32], 32'(tv[k].e_d1));
                chk("rs_busy", k, 32'(sb_if.rs_busy), 32'(tv[k].e_busy));
                chk("claim_ready", k, 32'(sb_if.claim_ready), 32'(tv[k].e_cr));
                chk("any_busy", k, 32'(sb_if.any_busy), 32'(tv[k].e_any));
                chk("sb_err", k, 32'(sb_if.sb_err), 32'(tv[k].e_err));
            end
            @(posedge CLK);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
